// File: rtl/arm_pkg.sv
// ---------------------------------------------------------------------------
// arm_pkg
// Shared definitions for the ARM pipeline memory path.
//   BASE_ADDR_DEFAULT : byte address of data-memory word 0 (shared with the
//                       single-cycle data memory so both keep one address map)
//   sram_state_e      : sequencing states of the SRAM controller
// ---------------------------------------------------------------------------
package arm_pkg;

  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } sram_state_e;

endpackage

// File: rtl/sram_controller.sv
// ---------------------------------------------------------------------------
// sram_controller
// Turns one 32-bit MEM-stage load/store into two 16-bit accesses on an
// external asynchronous SRAM, each held for WAIT_CYCLES cycles (>= 2).
// While an access runs, ready is low and the pipeline is frozen.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   wr_en, rd_en         store / load request (held stable while frozen)
//   address              byte address from the ALU
//   write_data           store value
//   read_data            registered load result
//   ready                high: MEM stage may advance; low: freeze
//   sram_addr            halfword address to the SRAM
//   sram_dq_out/_in/_oe  SRAM data pad: out value, in value, output enable
//   sram_we_n, sram_oe_n SRAM write strobe / output enable, active low
// ---------------------------------------------------------------------------
module sram_controller
  import arm_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 4,
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  localparam int unsigned      CNT_W    = $clog2(WAIT_CYCLES + 1);
  localparam int unsigned      IDX_W    = SRAM_AW - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  sram_state_e      state_r;
  sram_state_e      state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;

  logic             req_s;
  logic             last_s;
  logic             active_s;
  logic             capture_s;
  logic [IDX_W-1:0] word_idx_s;

  assign req_s    = rd_en | wr_en;
  assign last_s   = (cnt_r == CNT_LAST);
  assign active_s = (state_r == ST_LO) || (state_r == ST_HI);

  // Word index from the live address; out-of-range addresses wrap by truncation.
  assign word_idx_s = IDX_W'((address - BASE_ADDR) >> 2);

  // A pure read captures the pad on the final (hold) cycle of each phase.
  assign capture_s = active_s && last_s && rd_en && !wr_en;

  // Freeze unless the access just finished or nothing is requested.
  assign ready = (state_r == ST_DONE) || ((state_r == ST_IDLE) && !req_s);

  // State and wait-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state and wait-counter logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (req_s) begin
          state_s = ST_LO;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LO: begin
        if (last_s) begin
          state_s = ST_HI;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_HI: begin
        if (last_s) begin
          state_s = ST_DONE;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_DONE: begin
        // The request still visible here is the one just served.
        state_s = ST_IDLE;
        cnt_s   = {CNT_W{1'b0}};
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // SRAM pin decode from the current phase; idle pins sit at their safe values.
  always_comb begin
    sram_addr   = {SRAM_AW{1'b0}};
    sram_dq_out = 16'h0000;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    sram_oe_n   = 1'b1;
    if (active_s) begin
      if (state_r == ST_HI) begin
        sram_addr = {word_idx_s, 1'b1};
      end else begin
        sram_addr = {word_idx_s, 1'b0};
      end
      if (wr_en) begin
        // Write wins when both requests are set.
        sram_dq_oe = 1'b1;
        sram_oe_n  = 1'b1;
        // Strobe released on the last cycle so address/data are held past WE rise.
        sram_we_n  = last_s;
        if (state_r == ST_HI) begin
          sram_dq_out = write_data[31:16];
        end else begin
          sram_dq_out = write_data[15:0];
        end
      end else begin
        sram_dq_oe  = 1'b0;
        sram_dq_out = 16'h0000;
        sram_we_n   = 1'b1;
        sram_oe_n   = 1'b0;
      end
    end else begin
      sram_addr   = {SRAM_AW{1'b0}};
      sram_dq_out = 16'h0000;
      sram_dq_oe  = 1'b0;
      sram_we_n   = 1'b1;
      sram_oe_n   = 1'b1;
    end
  end

  // Load result register; each half is written once per read access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data <= 32'h0000_0000;
    end else if (capture_s) begin
      if (state_r == ST_HI) begin
        read_data[31:16] <= sram_dq_in;
      end else begin
        read_data[15:0] <= sram_dq_in;
      end
    end else begin
      read_data <= read_data;
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// ---------------------------------------------------------------------------
// tb_sram_controller
// Directed bench with a behavioural SRAM. Each issued access pushes its
// expected completion record into a queue; a monitor pops and compares it
// when the controller raises ready at the end of an access.
// ---------------------------------------------------------------------------
module tb_sram_controller;

  localparam int W = 4;

  typedef struct {
    logic [31:0] exp_data;
    int          exp_freeze;
    int          exp_we_low;
    int          exp_oe_low;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address, write_data, read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n, sram_oe_n;

  logic [15:0] mem [0:63];

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  sram_controller #(.WAIT_CYCLES(W), .BASE_ADDR(32'd1024), .SRAM_AW(18)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
    .address(address), .write_data(write_data), .read_data(read_data),
    .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
    .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe),
    .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  always #5 clk = ~clk;

  // Behavioural asynchronous SRAM (small window of halfwords).
  assign sram_dq_in = (!sram_oe_n) ? mem[sram_addr[5:0]] : 16'h0000;
  always @(posedge clk) begin
    if (!sram_we_n && sram_dq_oe) mem[sram_addr[5:0]] <= sram_dq_out;
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: counts freeze / strobe cycles of the running access and scores
  // it against the queue when ready rises with the request still present.
  int freeze_cnt = 0, we_cnt = 0, oe_cnt = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      freeze_cnt = 0; we_cnt = 0; oe_cnt = 0;
    end else if (rd_en || wr_en) begin
      if (!ready) begin
        freeze_cnt++;
        if (!sram_we_n) we_cnt++;
        if (!sram_oe_n) oe_cnt++;
      end else if (freeze_cnt > 0) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_completion: got completion expected none");
        end else begin
          e = sb.pop_front();
          check32({e.name, "_freeze"}, 32'(freeze_cnt), 32'(e.exp_freeze));
          check32({e.name, "_we_low"}, 32'(we_cnt), 32'(e.exp_we_low));
          check32({e.name, "_oe_low"}, 32'(oe_cnt), 32'(e.exp_oe_low));
          check32({e.name, "_rdata"}, read_data, e.exp_data);
        end
        freeze_cnt = 0; we_cnt = 0; oe_cnt = 0;
      end
    end
  end

  // Drive a request (call just after a rising edge) and queue its expectation.
  task automatic start(input logic w, input logic r, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_rd, input string name);
    exp_t e;
    wr_en = w; rd_en = r; address = a; write_data = d;
    e.exp_data   = exp_rd;
    e.exp_freeze = 2 * W + 1;
    e.exp_we_low = w ? 2 * (W - 1) : 0;
    e.exp_oe_low = w ? 0 : 2 * W;
    e.name       = name;
    sb.push_back(e);
  endtask

  // Wait for the DONE cycle, then step past the DONE edge.
  task automatic wait_done(input string name);
    int n = 0;
    @(negedge clk);
    while (!ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got ready=0 expected ready=1 within 40 cycles", name);
    end
    @(posedge clk); #1;
  endtask

  task automatic go_idle();
    wr_en = 1'b0; rd_en = 1'b0; address = 32'h0; write_data = 32'h0;
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = 32'h0; write_data = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Reset / idle state
    check32("idle_ready", 32'(ready), 32'd1);
    check32("idle_we_n", 32'(sram_we_n), 32'd1);
    check32("idle_oe_n", 32'(sram_oe_n), 32'd1);
    check32("idle_dq_oe", 32'(sram_dq_oe), 32'd0);
    check32("idle_rdata", read_data, 32'h0);

    // Store 0xDEADBEEF to 1028 -> halfwords 2,3
    start(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 32'h0, "store1");
    wait_done("store1");
    go_idle();
    check32("mem_hw2", 32'(mem[2]), 32'h0000BEEF);
    check32("mem_hw3", 32'(mem[3]), 32'h0000DEAD);

    // Load it back
    start(1'b0, 1'b1, 32'd1028, 32'h0, 32'hDEADBEEF, "load1");
    wait_done("load1");
    go_idle();

    // Load followed by a store with the request line held across DONE
    start(1'b0, 1'b1, 32'd1028, 32'h0, 32'hDEADBEEF, "load_b2b");
    wait_done("load_b2b");
    start(1'b1, 1'b0, 32'd1032, 32'hCAFEF00D, 32'hDEADBEEF, "store_b2b");
    wait_done("store_b2b");
    go_idle();
    check32("mem_hw4", 32'(mem[4]), 32'h0000F00D);
    check32("mem_hw5", 32'(mem[5]), 32'h0000CAFE);

    // Both requests high: write wins, read_data untouched
    start(1'b1, 1'b1, 32'd1024, 32'h12345678, 32'hDEADBEEF, "both");
    wait_done("both");
    go_idle();
    check32("mem_hw0", 32'(mem[0]), 32'h00005678);
    check32("mem_hw1", 32'(mem[1]), 32'h00001234);

    // Reset pulse in the second HI cycle of a load (cycle 6 after request)
    wr_en = 1'b0; rd_en = 1'b1; address = 32'd1032;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check32("rst_ready", 32'(ready), 32'd0);
    check32("rst_we_n", 32'(sram_we_n), 32'd1);
    check32("rst_oe_n", 32'(sram_oe_n), 32'd1);
    check32("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
    check32("rst_addr", 32'(sram_addr), 32'h0);
    check32("rst_rdata", read_data, 32'h0);
    rd_en = 1'b0;
    #1;
    check32("rst_idle_ready", 32'(ready), 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // Fresh load after reset
    start(1'b0, 1'b1, 32'd1024, 32'h0, 32'h12345678, "load_after_rst");
    wait_done("load_after_rst");
    go_idle();
    repeat (2) @(posedge clk);

    check32("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
# sram_controller

Multi-cycle controller between the MEM stage of the 5-stage ARM pipeline and an external 16-bit asynchronous SRAM. It turns one 32-bit load or store into two 16-bit SRAM accesses, each held for a fixed number of wait cycles. While an access is in progress it drives `ready` low, and the top level uses that to freeze all pipeline registers. It replaces the single-cycle data memory in the MEM stage and keeps the same address map.

## Interface
Parameters:
- `WAIT_CYCLES`, default 4: cycles each 16-bit half-access is held; must be ≥ 2.
- `BASE_ADDR`, default 1024: byte address mapped to SRAM word 0.
- `SRAM_AW`, default 18: SRAM address width.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  store request from the MEM stage.
- `rd_en`  in  1  load request from the MEM stage.
- `address`  in  32  byte address (ALU result).
- `write_data`  in  32  store value (Rm).
- `read_data`  out  32  load result, registered.
- `ready`  out  1  high means the MEM stage may advance; low means freeze the pipeline.
- `sram_addr`  out  SRAM_AW  halfword address.
- `sram_dq_out`  out  16  write data to the SRAM pad.
- `sram_dq_in`  in  16  read data from the SRAM pad.
- `sram_dq_oe`  out  1  pad output enable; high drives `sram_dq_out`.
- `sram_we_n`  out  1  SRAM write strobe, active low.
- `sram_oe_n`  out  1  SRAM output enable, active low.

## Operation
- Word index: `idx = (address - BASE_ADDR) >> 2`, computed in 32 bits and then truncated.
  - Low half-access: `sram_addr = {idx[SRAM_AW-2:0], 1'b0}`.
  - High half-access: `sram_addr = {idx[SRAM_AW-2:0], 1'b1}`.
  - An address outside the SRAM range wraps silently by truncation.
- The address is computed from the live inputs; the MEM stage holds them stable because the pipeline is frozen.
- States: IDLE, LO, HI, DONE.
- Wait counter `cnt`, width $clog2(WAIT_CYCLES+1).
- Transitions:
  - IDLE → LO when `rd_en | wr_en`; `cnt` ← 0.
  - LO → HI when `cnt == WAIT_CYCLES-1`; otherwise `cnt` increments. `cnt` ← 0 on exit.
  - HI → DONE when `cnt == WAIT_CYCLES-1`.
  - DONE → IDLE unconditionally. The request still present in DONE belongs to the access just completed and is not restarted.
- If `wr_en` and `rd_en` are both high, the access is a write and `read_data` is unchanged.
- Writes, in LO/HI:
  - `sram_dq_oe = 1`.
  - `sram_dq_out` = `write_data[15:0]` in LO, `write_data[31:16]` in HI.
  - `sram_we_n = 0` for every cycle of the phase except its last (`cnt == WAIT_CYCLES-1`), which gives address/data hold.
  - `sram_oe_n = 1`.
- Reads, in LO/HI:
  - `sram_oe_n = 0`, `sram_dq_oe = 0`.
  - `sram_dq_in` is captured into `read_data[15:0]` on the last LO cycle and into `read_data[31:16]` on the last HI cycle.
- Outside LO/HI: `sram_we_n = 1`, `sram_oe_n = 1`, `sram_dq_oe = 0`, `sram_addr = 0`, `sram_dq_out = 0`.
- `ready` (combinational) = DONE, or (IDLE and no request).
- `read_data` holds its value until the next read capture.

## Timing
- Request first seen in IDLE at cycle 0: `ready` goes low in cycle 0 with no registered delay.
- LO occupies cycles 1..W, HI occupies cycles W+1..2W, DONE is cycle 2W+1 with `ready = 1` (W = `WAIT_CYCLES`).
- `ready` is low for 2W+1 cycles per access; W = 4 gives 9 freeze cycles.
- `read_data` is final from the DONE cycle onward, and the pipeline latches it at the DONE edge.
- Back-to-back accesses: a new request seen in IDLE one cycle after DONE starts immediately, so there is exactly one IDLE cycle between accesses.
- Reset values: state IDLE, `cnt` 0, `read_data` 0, `sram_we_n` 1, `sram_oe_n` 1, `sram_dq_oe` 0, `sram_addr` 0, `sram_dq_out` 0. `ready` equals `!(rd_en | wr_en)` while in reset.
- `rst` asserted mid-access aborts immediately, asynchronously. A partially written SRAM word is acceptable.

## Structure
- Shared `arm_pkg` holds:
  - the state enum: IDLE, LO, HI, DONE;
  - the `BASE_ADDR` default constant (1024), also used by the existing data memory.
- One module, no sub-module. The FSM and counter fit in roughly 150 lines.
- The top level ties `sram_controller`'s `ready` into the pipeline freeze, ORed into `freeze` on the IF, ID, EXE and MEM registers, and keeps it separate from hazard freeze.

## Test plan
- Reset, then idle with no request: `ready = 1`, `sram_we_n = 1`, `sram_oe_n = 1`, `sram_dq_oe = 0`, `read_data = 0`.
- Store 0xDEADBEEF to address 1028, W = 4:
  - `ready` is low for 9 cycles;
  - SRAM model holds 0xBEEF at halfword 2 and 0xDEAD at halfword 3;
  - `sram_we_n` is low for 3 of the 4 cycles of each phase.
- Load from 1028 after that store: `read_data = 0xDEADBEEF` in the DONE cycle, with `ready` high only in that cycle.
- Load, then a store held asserted across DONE:
  - exactly one IDLE cycle between the two accesses;
  - the second access follows the same LO/HI sequence;
  - the load data is unaffected.
- `rd_en` and `wr_en` both high with `write_data = 0x12345678` at 1024: the write is performed, halfwords 0 and 1 become 0x5678 and 0x1234, and `read_data` is unchanged.
- `rst` pulsed in cycle 2 of HI during a load: outputs return to reset values immediately, state is IDLE, and a new load completes normally afterwards.
